keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad on the input side of the clock design and produces debounced key events for the time-adjust and control logic. It drives one row low at a time, samples the four columns, and reports a single stable key code. Row selection is time-multiplexed, mirroring how the 7-segment digit selects are scanned on the output side. The block runs on the 48 MHz system clock and divides the scan rate internally.

---
 rtl/keypad_scanner.sv | 179 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low row strobe, samples the columns once
// per row slot, classifies each full frame and debounces press/release on frame results.
module keypad_scanner #(
  parameter int SCAN_DIV       = 48000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_48mhz,
  input  logic       clear,
  input  logic [3:0] col_in,
  output logic [3:0] row_sel,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  // One extra code point so the debounce count can actually reach DEBOUNCE_SCANS.
  localparam int DB_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_TARGET = DB_W'(DEBOUNCE_SCANS);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_DB} state_t;

  logic [3:0]        col_meta_reg, col_sync_reg;
  logic [SLOT_W-1:0] slot_cnt_reg;
  logic [1:0]        row_idx_reg;
  logic [1:0]        hit_cnt_reg;
  logic [3:0]        hit_code_reg;
  state_t            state_reg, state_next;
  logic [3:0]        cand_reg, cand_next;
  logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
  logic [3:0]        key_code_reg, key_code_next;
  logic              key_valid_reg, key_valid_next;
  logic              key_held_reg, key_held_next;

  logic [3:0] col_hit;
  logic [2:0] row_hits;
  logic [1:0] col_pos;
  logic [1:0] base_cnt;
  logic [2:0] total_sum;
  logic [1:0] row_total;
  logic [3:0] row_code;
  logic       sample;
  logic       frame_done;
  logic [DB_W-1:0] db_inc;

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign col_hit[gi] = ~col_sync_reg[gi];
  end

  assign row_sel  = ~(4'b0001 << row_idx_reg);
  assign sample   = (slot_cnt_reg == SLOT_LAST);
  assign row_hits = {2'b00, col_hit[0]} + {2'b00, col_hit[1]}
                  + {2'b00, col_hit[2]} + {2'b00, col_hit[3]};
  assign col_pos  = col_hit[0] ? 2'd0 : col_hit[1] ? 2'd1 : col_hit[2] ? 2'd2 : 2'd3;

  // Row 0 starts a new frame, so the carried count is ignored there instead of cleared.
  assign base_cnt   = (row_idx_reg == 2'd0) ? 2'd0 : hit_cnt_reg;
  assign total_sum  = {1'b0, base_cnt} + row_hits;
  assign row_total  = (total_sum >= 3'd2) ? 2'd2 : total_sum[1:0];
  assign row_code   = (base_cnt == 2'd0 && row_hits == 3'd1) ? {row_idx_reg, col_pos} : hit_code_reg;
  assign frame_done = sample && (row_idx_reg == 2'd3);
  assign db_inc     = db_cnt_reg + DB_ONE;

  always_ff @(posedge clk_48mhz or posedge clear) begin
    if (clear) begin
      col_meta_reg <= 4'b1111;
      col_sync_reg <= 4'b1111;
      slot_cnt_reg <= '0;
      row_idx_reg  <= 2'd0;
      hit_cnt_reg  <= 2'd0;
      hit_code_reg <= 4'd0;
    end else begin
      col_meta_reg <= col_in;
      col_sync_reg <= col_meta_reg;
      if (sample) begin
        slot_cnt_reg <= '0;
        row_idx_reg  <= row_idx_reg + 2'd1;
        if (row_idx_reg != 2'd3) begin
          hit_cnt_reg  <= row_total;
          hit_code_reg <= row_code;
        end
      end else begin
        slot_cnt_reg <= slot_cnt_reg + SLOT_W'(1);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    cand_next      = cand_reg;
    db_cnt_next    = db_cnt_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;
    if (frame_done) begin
      case (state_reg)
        IDLE: begin
          if (row_total == 2'd1) begin
            cand_next   = row_code;
            db_cnt_next = DB_ONE;
            if (DB_TARGET == DB_ONE) begin
              state_next     = PRESSED;
              key_code_next  = row_code;
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
            end else begin
              state_next = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (row_total == 2'd1 && row_code == cand_reg) begin
            db_cnt_next = db_inc;
            if (db_inc == DB_TARGET) begin
              state_next     = PRESSED;
              key_code_next  = cand_reg;
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
            end
          end else if (row_total == 2'd1) begin
            cand_next   = row_code;
            db_cnt_next = DB_ONE;
          end else begin
            state_next = IDLE;
          end
        end
        PRESSED: begin
          // A second key while held is ignored; only a clean NONE frame starts release.
          if (row_total == 2'd0) begin
            db_cnt_next = DB_ONE;
            if (DB_TARGET == DB_ONE) begin
              state_next    = IDLE;
              key_held_next = 1'b0;
            end else begin
              state_next = REL_DB;
            end
          end
        end
        REL_DB: begin
          if (row_total == 2'd0) begin
            db_cnt_next = db_inc;
            if (db_inc == DB_TARGET) begin
              state_next    = IDLE;
              key_held_next = 1'b0;
            end
          end else begin
            state_next = PRESSED;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_48mhz or posedge clear) begin
    if (clear) begin
      state_reg     <= IDLE;
      cand_reg      <= 4'd0;
      db_cnt_reg    <= '0;
      key_code_reg  <= 4'd0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cand_reg      <= cand_next;
      db_cnt_reg    <= db_cnt_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: a key-matrix model drives col_in from row_sel; accepted key codes
// are queued by the stimulus and matched against key_valid pulses by a separate monitor.
module tb_keypad_scanner;

  logic       clk_48mhz;
  logic       clear;
  logic [3:0] col_in;
  logic [3:0] row_sel;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  logic [3:0]  exp_q[$];
  int          checks;
  int          errors;
  bit          done;

  localparam int FRAME = 16;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk_48mhz (clk_48mhz),
    .clear     (clear),
    .col_in    (col_in),
    .row_sel   (row_sel),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk_48mhz = 1'b0;
  always #5 clk_48mhz = ~clk_48mhz;

  // Passive matrix: a pressed key shorts its column to the driven (low) row.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_sel[r] && pressed[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_48mhz);
  endtask

  // Monitor: every key_valid pulse must match the next queued code and never repeat.
  initial begin
    logic       prev_valid;
    logic [3:0] e;
    prev_valid = 1'b0;
    while (!done) begin
      @(negedge clk_48mhz);
      if (key_valid === 1'b1) begin
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL valid_double: got two consecutive pulses, want one");
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL valid_unexpected: got code %0d, want no pulse", key_code);
        end else begin
          e = exp_q.pop_front();
          if (key_code !== e) begin
            errors++;
            $display("FAIL valid_code: got %0d want %0d", key_code, e);
          end else begin
            $display("ok   key_valid code=%0d", key_code);
          end
        end
      end
      prev_valid = key_valid;
    end
  end

  initial begin
    logic [3:0] exp_row;
    done    = 1'b0;
    checks  = 0;
    errors  = 0;
    pressed = 16'h0000;
    clear   = 1'b1;

    // Reset state, then a mid-slot clear must force outputs immediately.
    wait_cycles(3);
    chk("rst_row_sel", row_sel, 4'b1110);
    chk("rst_code", key_code, 4'd0);
    chk("rst_valid", {3'b000, key_valid}, 4'd0);
    chk("rst_held", {3'b000, key_held}, 4'd0);
    clear = 1'b0;
    wait_cycles(6);
    #2 clear = 1'b1;
    #1;
    chk("clr_row_sel", row_sel, 4'b1110);
    chk("clr_held", {3'b000, key_held}, 4'd0);
    @(negedge clk_48mhz);
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_row = 4'b0001 << (i % 4);
      exp_row = ~exp_row;
      chk($sformatf("row_sel_slot%0d", i), row_sel, exp_row);
      wait_cycles(4);
    end

    // Clean press of key (2,1).
    exp_q.push_back(4'd9);
    pressed = 16'h0001 << 9;
    wait_cycles(4 * FRAME);
    chk("press9_held", {3'b000, key_held}, 4'd1);
    chk("press9_code", key_code, 4'd9);
    pressed = 16'h0000;
    wait_cycles(FRAME);
    chk("rel9_mid_held", {3'b000, key_held}, 4'd1);
    wait_cycles(3 * FRAME);
    chk("rel9_held", {3'b000, key_held}, 4'd0);
    chk("rel9_code", key_code, 4'd9);

    // Bounce on key (0,3): present, absent, present must not be accepted.
    pressed = 16'h0001 << 3;
    wait_cycles(FRAME);
    pressed = 16'h0000;
    wait_cycles(FRAME);
    exp_q.push_back(4'd3);
    pressed = 16'h0001 << 3;
    wait_cycles(4 * FRAME);
    chk("bounce_held", {3'b000, key_held}, 4'd1);
    chk("bounce_code", key_code, 4'd3);
    pressed = 16'h0000;
    wait_cycles(4 * FRAME);
    chk("bounce_rel_held", {3'b000, key_held}, 4'd0);

    // Two keys at once are rejected; the survivor is accepted once the other lifts.
    pressed = (16'h0001 << 4) | (16'h0001 << 14);
    wait_cycles(4 * FRAME);
    chk("multi_held", {3'b000, key_held}, 4'd0);
    exp_q.push_back(4'd4);
    pressed = 16'h0001 << 4;
    wait_cycles(4 * FRAME);
    chk("multi_rel_held", {3'b000, key_held}, 4'd1);
    chk("multi_rel_code", key_code, 4'd4);
    pressed = 16'h0000;
    wait_cycles(4 * FRAME);
    chk("multi_clear_held", {3'b000, key_held}, 4'd0);

    // Rollover: 5 held, 10 added, 5 released; no new acceptance until all released.
    exp_q.push_back(4'd5);
    pressed = 16'h0001 << 5;
    wait_cycles(4 * FRAME);
    pressed = (16'h0001 << 5) | (16'h0001 << 10);
    wait_cycles(4 * FRAME);
    pressed = 16'h0001 << 10;
    wait_cycles(4 * FRAME);
    chk("roll_held", {3'b000, key_held}, 4'd1);
    chk("roll_code", key_code, 4'd5);
    pressed = 16'h0000;
    wait_cycles(FRAME);
    chk("roll_rel_mid_held", {3'b000, key_held}, 4'd1);
    wait_cycles(4 * FRAME);
    chk("roll_rel_held", {3'b000, key_held}, 4'd0);
    chk("roll_rel_code", key_code, 4'd5);

    // Clear after one matching frame restarts debounce from scratch.
    clear   = 1'b1;
    pressed = 16'h0001 << 7;
    #1;
    chk("clr2_code", key_code, 4'd0);
    @(negedge clk_48mhz);
    clear = 1'b0;
    wait_cycles(20);
    clear = 1'b1;
    #1;
    chk("clr3_held", {3'b000, key_held}, 4'd0);
    wait_cycles(3);
    clear = 1'b0;
    exp_q.push_back(4'd7);
    wait_cycles(20);
    chk("fresh1_held", {3'b000, key_held}, 4'd0);
    wait_cycles(20);
    chk("fresh2_held", {3'b000, key_held}, 4'd1);
    chk("fresh2_code", key_code, 4'd7);
    pressed = 16'h0000;
    wait_cycles(4 * FRAME);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending presses, want 0", exp_q.size());
    end
    done = 1'b1;
    @(negedge clk_48mhz);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
